// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control: FSM states, opcodes,
// datapath mux codes and the control word driven by the output decoder.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_R_EXEC    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_I_EXEC    = 4'd8,
        ST_I_WB      = 4'd9,
        ST_BRANCH    = 4'd10,
        ST_JUMP      = 4'd11,
        ST_JAL       = 4'd12,
        ST_JR        = 4'd13,
        ST_TRAP      = 4'd14
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_AND   = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
        logic       instr_done;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // DECODE dispatch; anything not recognised lands in the absorbing TRAP state.
    function automatic state_e dispatch(input logic [5:0] op, input logic [5:0] fn);
        state_e nxt;
        case (op)
            OP_RTYPE:     nxt = (fn == FN_JR) ? ST_JR : ST_R_EXEC;
            OP_LW, OP_SW: nxt = ST_MEM_ADDR;
            OP_ADDI,
            OP_ANDI:      nxt = ST_I_EXEC;
            OP_BEQ:       nxt = ST_BRANCH;
            OP_J:         nxt = ST_JUMP;
            OP_JAL:       nxt = ST_JAL;
            default:      nxt = ST_TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mips_multicycle_control_outdec.sv
// Moore output decoder: state (+ opcode latched in DECODE, + mem_ready when
// MC_CTRL_MEM_WAIT_EN is defined) -> datapath control word.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  state_e              state_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                mem_ready_i,
    output ctrl_t               ctrl_o
);

    logic ready_s;
`ifdef MC_CTRL_MEM_WAIT_EN
    assign ready_s = mem_ready_i;
`else
    logic unused_ready_s;
    assign unused_ready_s = mem_ready_i;
    assign ready_s        = 1'b1;
`endif

    // Per-state control word; strobes held during waits, one-shot loads gated by ready.
    always_comb begin
        ctrl_o = CTRL_IDLE;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.ir_write  = ready_s;
                ctrl_o.pc_write  = ready_s;
            end
            ST_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH;
            end
            ST_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            ST_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = M2R_MDR;
                ctrl_o.instr_done = 1'b1;
            end
            ST_MEM_WRITE: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.iord       = 1'b1;
                ctrl_o.instr_done = ready_s;
            end
            ST_R_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            ST_R_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RD;
                ctrl_o.instr_done = 1'b1;
            end
            ST_I_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = (opcode_i == OPCODE_W'(OP_ANDI)) ? ALU_AND : ALU_ADD;
            end
            ST_I_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.instr_done    = 1'b1;
            end
            ST_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            ST_JAL: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RA;
                ctrl_o.mem_to_reg = M2R_PC;
                ctrl_o.instr_done = 1'b1;
            end
            ST_JR: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_REG;
                ctrl_o.instr_done = 1'b1;
            end
            ST_TRAP: begin
                ctrl_o.illegal = 1'b1;
            end
            default: begin
                ctrl_o = CTRL_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control FSM with opcode latch, sticky illegal trap and
// retired-instruction counter. MC_CTRL_MEM_WAIT_EN enables memory wait states.
module mips_multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6,
    parameter int CNT_W    = 32
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [OPCODE_W-1:0] op_code_i,
    input  logic [FUNCT_W-1:0]  funct_i,
    input  logic                mem_ready_i,
    output logic                pc_write_o,
    output logic                pc_write_cond_o,
    output logic                iord_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                ir_write_o,
    output logic [1:0]          mem_to_reg_o,
    output logic [1:0]          reg_dst_o,
    output logic                reg_write_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [1:0]          alu_op_o,
    output logic [1:0]          pc_source_o,
    output logic                illegal_o,
    output logic                instr_done_o,
    output logic [CNT_W-1:0]    instr_count_o
);

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q;
    logic                illegal_q;
    logic [CNT_W-1:0]    count_q;
    ctrl_t               ctrl_s, ctrl_out_s;
    logic                ready_s;

`ifdef MC_CTRL_MEM_WAIT_EN
    assign ready_s = mem_ready_i;
`else
    assign ready_s = 1'b1;
`endif

    mc_ctrl_outdec #(.OPCODE_W(OPCODE_W)) u_outdec (
        .state_i     (state_q),
        .opcode_i    (opcode_q),
        .mem_ready_i (mem_ready_i),
        .ctrl_o      (ctrl_s)
    );

    // Next-state sequencing; MEM_ADDR uses the latched opcode since the IR may move on.
    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:     state_d = ready_s ? ST_DECODE : ST_FETCH;
            ST_DECODE:    state_d = dispatch(6'(op_code_i), 6'(funct_i));
            ST_MEM_ADDR:  state_d = (opcode_q == OPCODE_W'(OP_SW)) ? ST_MEM_WRITE : ST_MEM_READ;
            ST_MEM_READ:  state_d = ready_s ? ST_MEM_WB : ST_MEM_READ;
            ST_MEM_WRITE: state_d = ready_s ? ST_FETCH : ST_MEM_WRITE;
            ST_R_EXEC:    state_d = ST_R_WB;
            ST_I_EXEC:    state_d = ST_I_WB;
            ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH,
            ST_JUMP, ST_JAL, ST_JR:
                          state_d = ST_FETCH;
            ST_TRAP:      state_d = ST_TRAP;
            default:      state_d = ST_FETCH;
        endcase
    end

    // State register, opcode latch, sticky trap flag and retired-instruction counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_FETCH;
            opcode_q  <= '0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | (state_d == ST_TRAP);
            if (state_q == ST_DECODE) begin
                opcode_q <= op_code_i;
            end
            if (ctrl_s.instr_done) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    // Reset forces a quiet datapath immediately, not just from the next edge.
    assign ctrl_out_s = reset_i ? CTRL_IDLE : ctrl_s;

    assign pc_write_o      = ctrl_out_s.pc_write;
    assign pc_write_cond_o = ctrl_out_s.pc_write_cond;
    assign iord_o          = ctrl_out_s.iord;
    assign mem_read_o      = ctrl_out_s.mem_read;
    assign mem_write_o     = ctrl_out_s.mem_write;
    assign ir_write_o      = ctrl_out_s.ir_write;
    assign mem_to_reg_o    = ctrl_out_s.mem_to_reg;
    assign reg_dst_o       = ctrl_out_s.reg_dst;
    assign reg_write_o     = ctrl_out_s.reg_write;
    assign alu_src_a_o     = ctrl_out_s.alu_src_a;
    assign alu_src_b_o     = ctrl_out_s.alu_src_b;
    assign alu_op_o        = ctrl_out_s.alu_op;
    assign pc_source_o     = ctrl_out_s.pc_source;
    assign instr_done_o    = ctrl_out_s.instr_done;
    assign illegal_o       = illegal_q & ~reset_i;
    assign instr_count_o   = reset_i ? '0 : count_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Table-driven bench for mips_multicycle_control (CNT_W=4 so the counter wraps);
// memory-wait sequences depend on MC_CTRL_MEM_WAIT_EN.
module tb_mips_multicycle_control;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic [5:0] op_code_i = 6'd0;
    logic [5:0] funct_i = 6'd0;
    logic       mem_ready_i = 1'b1;
    logic       pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o, ir_write_o;
    logic [1:0] mem_to_reg_o, reg_dst_o, alu_src_b_o, alu_op_o, pc_source_o;
    logic       reg_write_o, alu_src_a_o, illegal_o, instr_done_o;
    logic [3:0] instr_count_o;
    logic [19:0] act_w;

    int total = 0;
    int bad = 0;

    always #5 clk_i = ~clk_i;

    mips_multicycle_control #(.OPCODE_W(6), .FUNCT_W(6), .CNT_W(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .op_code_i(op_code_i), .funct_i(funct_i),
        .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o),
        .iord_o(iord_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .ir_write_o(ir_write_o), .mem_to_reg_o(mem_to_reg_o), .reg_dst_o(reg_dst_o),
        .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .alu_op_o(alu_op_o), .pc_source_o(pc_source_o), .illegal_o(illegal_o),
        .instr_done_o(instr_done_o), .instr_count_o(instr_count_o)
    );

    assign act_w = {pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o, ir_write_o,
                    mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o,
                    alu_op_o, pc_source_o, illegal_o, instr_done_o};

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [19:0] w;
        logic [3:0]  c;
        string       tag;
    } vec_t;

    vec_t vq[$];

    function automatic logic [19:0] mk(input logic pw, input logic pwc, input logic io,
                                       input logic mr, input logic mw, input logic irw,
                                       input logic [1:0] m2r, input logic [1:0] rd,
                                       input logic rw, input logic asa, input logic [1:0] asb,
                                       input logic [1:0] aop, input logic [1:0] ps,
                                       input logic ill, input logic done);
        return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps, ill, done};
    endfunction

    task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic [19:0] w, input logic [3:0] c, input string tag);
        vec_t v;
        v.rst = rst; v.op = op; v.fn = fn; v.w = w; v.c = c; v.tag = tag;
        vq.push_back(v);
    endtask

    // One clock cycle: drive inputs, compare outputs mid-cycle, advance past the edge.
    task automatic cyc(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic rdy, input logic [19:0] w, input logic [3:0] c,
                       input string tag);
        reset_i = rst; op_code_i = op; funct_i = fn; mem_ready_i = rdy;
        #4;
        total++;
        if (act_w !== w) begin
            bad++;
            $display("FAIL %s ctrl got=%05h want=%05h", tag, act_w, w);
        end
        total++;
        if (instr_count_o !== c) begin
            bad++;
            $display("FAIL %s count got=%0d want=%0d", tag, instr_count_o, c);
        end
        @(posedge clk_i);
        #1;
    endtask

    logic [19:0] e_zero, e_fetch, e_dec, e_maddr, e_mrd, e_mwb, e_mwr, e_rex, e_rwb;
    logic [19:0] e_iadd, e_iand, e_iwb, e_br, e_j, e_jal, e_jr, e_trap, e_fwait, e_mwwait;
    logic [3:0]  n;

    initial begin
        e_zero  = 20'd0;
        e_fetch = mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,2'b00,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0);
        e_dec   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0);
        e_maddr = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0);
        e_mrd   = mk(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);
        e_mwb   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1);
        e_mwr   = mk(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1);
        e_rex   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0);
        e_rwb   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1);
        e_iadd  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0);
        e_iand  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b10,2'b11,2'b00,1'b0,1'b0);
        e_iwb   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1);
        e_br    = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0,1'b1);
        e_j     = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0,1'b1);
        e_jal   = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b10,1'b1,1'b0,2'b00,2'b00,2'b10,1'b0,1'b1);
        e_jr    = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,2'b00,2'b11,1'b0,1'b1);
        e_trap  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0);
        e_fwait = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0);
        e_mwwait= mk(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);

        for (int i = 0; i < 3; i++) add(1'b1, 6'd0, 6'd0, e_zero, 4'd0, "reset");
        add(1'b0, 6'd0,       6'd0,       e_fetch, 4'd0, "lw_fetch");
        add(1'b0, 6'b100011,  6'd0,       e_dec,   4'd0, "lw_decode");
        add(1'b0, 6'd0,       6'd0,       e_maddr, 4'd0, "lw_memaddr");
        add(1'b0, 6'd0,       6'd0,       e_mrd,   4'd0, "lw_memread");
        add(1'b0, 6'd0,       6'd0,       e_mwb,   4'd0, "lw_memwb");
        add(1'b0, 6'd0,       6'd0,       e_fetch, 4'd1, "sw_fetch");
        add(1'b0, 6'b101011,  6'd0,       e_dec,   4'd1, "sw_decode");
        add(1'b0, 6'd0,       6'd0,       e_maddr, 4'd1, "sw_memaddr");
        add(1'b0, 6'd0,       6'd0,       e_mwr,   4'd1, "sw_memwrite");
        add(1'b0, 6'd0,       6'd0,       e_fetch, 4'd2, "r_fetch");
        add(1'b0, 6'b000000,  6'b100000,  e_dec,   4'd2, "r_decode");
        add(1'b0, 6'd0,       6'd0,       e_rex,   4'd2, "r_exec");
        add(1'b0, 6'd0,       6'd0,       e_rwb,   4'd2, "r_wb");
        add(1'b0, 6'd0,       6'd0,       e_fetch, 4'd3, "jr_fetch");
        add(1'b0, 6'b000000,  6'b001000,  e_dec,   4'd3, "jr_decode");
        add(1'b0, 6'd0,       6'd0,       e_jr,    4'd3, "jr_exec");
        add(1'b0, 6'd0,       6'd0,       e_fetch, 4'd4, "addi_fetch");
        add(1'b0, 6'b001000,  6'd0,       e_dec,   4'd4, "addi_decode");
        add(1'b0, 6'b001100,  6'd0,       e_iadd,  4'd4, "addi_exec_oplatch");
        add(1'b0, 6'd0,       6'd0,       e_iwb,   4'd4, "addi_wb");
        add(1'b0, 6'd0,       6'd0,       e_fetch, 4'd5, "andi_fetch");
        add(1'b0, 6'b001100,  6'd0,       e_dec,   4'd5, "andi_decode");
        add(1'b0, 6'b001000,  6'd0,       e_iand,  4'd5, "andi_exec_oplatch");
        add(1'b0, 6'd0,       6'd0,       e_iwb,   4'd5, "andi_wb");
        add(1'b0, 6'd0,       6'd0,       e_fetch, 4'd6, "beq_fetch");
        add(1'b0, 6'b000100,  6'd0,       e_dec,   4'd6, "beq_decode");
        add(1'b0, 6'd0,       6'd0,       e_br,    4'd6, "beq_branch");
        add(1'b0, 6'd0,       6'd0,       e_fetch, 4'd7, "j_fetch");
        add(1'b0, 6'b000010,  6'd0,       e_dec,   4'd7, "j_decode");
        add(1'b0, 6'd0,       6'd0,       e_j,     4'd7, "j_jump");
        add(1'b0, 6'd0,       6'd0,       e_fetch, 4'd8, "jal_fetch");
        add(1'b0, 6'b000011,  6'd0,       e_dec,   4'd8, "jal_decode");
        add(1'b0, 6'd0,       6'd0,       e_jal,   4'd8, "jal_link");
        add(1'b0, 6'd0,       6'd0,       e_fetch, 4'd9, "trap_fetch");
        add(1'b0, 6'b111111,  6'd0,       e_dec,   4'd9, "trap_decode");
        for (int i = 0; i < 20; i++) add(1'b0, 6'b100011, 6'd0, e_trap, 4'd9, "trap_hold");
        add(1'b1, 6'd0,       6'd0,       e_zero,  4'd0, "trap_reset");
        add(1'b0, 6'd0,       6'd0,       e_fetch, 4'd0, "abort_fetch");
        add(1'b0, 6'b100011,  6'd0,       e_dec,   4'd0, "abort_decode");
        add(1'b0, 6'd0,       6'd0,       e_maddr, 4'd0, "abort_memaddr");
        add(1'b1, 6'd0,       6'd0,       e_zero,  4'd0, "abort_reset_memread");
        for (int k = 0; k < 16; k++) begin
            n = 4'(k);
            add(1'b0, 6'd0,      6'd0, e_fetch, n, "wrap_fetch");
            add(1'b0, 6'b001000, 6'd0, e_dec,   n, "wrap_decode");
            add(1'b0, 6'd0,      6'd0, e_iadd,  n, "wrap_exec");
            add(1'b0, 6'd0,      6'd0, e_iwb,   n, "wrap_wb");
        end
        add(1'b0, 6'd0,       6'd0,       e_fetch, 4'd0, "wrap_to_zero");
        add(1'b1, 6'd0,       6'd0,       e_zero,  4'd0, "final_reset");

        foreach (vq[i]) cyc(vq[i].rst, vq[i].op, vq[i].fn, 1'b1, vq[i].w, vq[i].c, vq[i].tag);

`ifdef MC_CTRL_MEM_WAIT_EN
        cyc(1'b0, 6'd0,      6'd0, 1'b0, e_fwait,  4'd0, "wait_fetch_hold");
        cyc(1'b0, 6'd0,      6'd0, 1'b1, e_fetch,  4'd0, "wait_fetch_go");
        cyc(1'b0, 6'b101011, 6'd0, 1'b1, e_dec,    4'd0, "wait_sw_decode");
        cyc(1'b0, 6'd0,      6'd0, 1'b0, e_maddr,  4'd0, "wait_sw_memaddr");
        for (int i = 0; i < 3; i++) cyc(1'b0, 6'd0, 6'd0, 1'b0, e_mwwait, 4'd0, "wait_sw_hold");
        cyc(1'b0, 6'd0,      6'd0, 1'b1, e_mwr,    4'd0, "wait_sw_done");
        cyc(1'b0, 6'd0,      6'd0, 1'b1, e_fetch,  4'd1, "wait_next_fetch");
`else
        cyc(1'b0, 6'd0,      6'd0, 1'b0, e_fetch,  4'd0, "noready_fetch");
        cyc(1'b0, 6'b101011, 6'd0, 1'b0, e_dec,    4'd0, "noready_decode");
        cyc(1'b0, 6'd0,      6'd0, 1'b0, e_maddr,  4'd0, "noready_memaddr");
        cyc(1'b0, 6'd0,      6'd0, 1'b0, e_mwr,    4'd0, "noready_memwrite");
        cyc(1'b0, 6'd0,      6'd0, 1'b0, e_fetch,  4'd1, "noready_next_fetch");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
